frame_writer: RTL and testbench
===============================

FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 24, memory word address width.
REQ-002 SHALL have parameter STRAND_PARAM_WIDTH, default 16, width of strand offset/length.
REQ-003 SHALL have parameter MEM_DATA_WIDTH, default 24, one RGB pixel per memory word.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse, begin loading one strand.
REQ-007 strand_offset  input  STRAND_PARAM_WIDTH  base word address of strand, sampled on start.
REQ-008 strand_length  input  STRAND_PARAM_WIDTH  pixel count of strand, sampled on start.
REQ-009 in_data  input  8  host byte stream, R then G then B.
REQ-010 in_valid  input  1  in_data valid.
REQ-011 in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-012 mem_addr  output  MEM_ADDR_WIDTH  write word address.
REQ-013 mem_wdata  output  MEM_DATA_WIDTH  {R,G,B}, R in MSBs.
REQ-014 mem_we  output  1  write request, held until mem_ack.
REQ-015 mem_ack  input  1  write accepted this cycle when mem_we && mem_ack.
REQ-016 busy  output  1  high outside IDLE.
REQ-017 done  output  1  one-cycle pulse, strand complete.

Function
REQ-018 States SHALL be IDLE, COLLECT, WRITE, DONE.
REQ-019 IDLE: start latches strand_offset/strand_length, clears pixel index and byte counter, goes to COLLECT; if latched length is 0, goes to DONE instead.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 in_ready SHALL be 1 only in COLLECT; bytes are never accepted in other states.
REQ-022 COLLECT: each accepted byte fills R, G, B slot in order; third byte moves to WRITE next cycle with mem_we=1.
REQ-023 mem_addr SHALL equal zero-extended strand_offset + pixel index, computed at MEM_ADDR_WIDTH bits, no modulo wrap.
REQ-024 WRITE: mem_addr, mem_wdata, mem_we SHALL be stable until mem_ack; on ack, index increments; if new index == latched length go to DONE, else COLLECT.
REQ-025 mem_ack without mem_we SHALL be ignored.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 Latency: last byte accepted at cycle N -> mem_we high at N+1; ack at M -> done at M+1 (last pixel).
REQ-028 Byte counter SHALL wrap 2->0; index width STRAND_PARAM_WIDTH, length 0xFFFF SHALL complete without overflow.

Reset
REQ-029 rst SHALL, in any state including mid-write, force IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, counters 0, partial pixel discarded.

Configuration
REQ-030 With FRAME_WRITER_CHECKSUM_EN defined, SHALL add output checksum [7:0]: 8-bit modulo-256 sum of all bytes accepted since last start, cleared on start and reset, held after done.
REQ-031 Without FRAME_WRITER_CHECKSUM_EN, port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 State encoding enum and default width constants SHALL live in shared package hydra_pkg.
REQ-033 A sub-module pixel_packer (byte counter, 3-byte to 24-bit assembly) SHALL be used; FSM and address logic stay in frame_writer.

Verification
REQ-034 start, offset=0x0100, length=2, bytes 11 22 33 44 55 66, ack immediate -> writes 0x000100<=0x112233, 0x000101<=0x445566, one done pulse.
REQ-035 length=0 start -> no mem_we, done 2 cycles after start, in_ready never high.
REQ-036 offset=0xFFFF, length=2 -> addresses 0x00FFFF then 0x010000.
REQ-037 mem_ack delayed 5 cycles -> mem_addr/mem_wdata/mem_we stable, in_ready=0 throughout; in_valid bytes not consumed.
REQ-038 rst asserted after 4 of 6 bytes -> IDLE next cycle, all outputs 0; new start length=1 bytes AA BB CC -> single write 0xAABBCC.
REQ-039 With FRAME_WRITER_CHECKSUM_EN, bytes 0xFF 0x02 0x01 -> checksum 0x02 after done; start while busy -> ignored, checksum unaffected.

Source files
------------

// File: rtl/hydra_pkg.sv
// rtl/hydra_pkg.sv - shared state encoding and width defaults for the frame writer
package hydra_pkg;

  localparam int DEF_MEM_ADDR_WIDTH     = 24;
  localparam int DEF_STRAND_PARAM_WIDTH = 16;
  localparam int DEF_MEM_DATA_WIDTH     = 24;
  localparam int BYTE_WIDTH             = 8;
  localparam int PIXEL_WIDTH            = 3 * BYTE_WIDTH;

  localparam logic [1:0] LAST_BYTE_SLOT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic [BYTE_WIDTH-1:0] add_mod256(
    input logic [BYTE_WIDTH-1:0] acc,
    input logic [BYTE_WIDTH-1:0] data
  );
    return acc + data;
  endfunction

endpackage

// File: rtl/pixel_packer.sv
// rtl/pixel_packer.sv - gathers R, G, B bytes into one 24-bit pixel
// The blue byte is passed straight through so the pixel is complete in the cycle its last byte is accepted.
module pixel_packer
  import hydra_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [BYTE_WIDTH-1:0]  in_data,
  input  logic                   accept,
  output logic [PIXEL_WIDTH-1:0] pixel,
  output logic                   pixel_complete
);

  logic [1:0]            byte_cnt;
  logic [BYTE_WIDTH-1:0] r_q;
  logic [BYTE_WIDTH-1:0] g_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt <= 2'd0;
      r_q      <= '0;
      g_q      <= '0;
    end else if (accept) begin
      case (byte_cnt)
        2'd0: begin
          r_q      <= in_data;
          byte_cnt <= 2'd1;
        end
        2'd1: begin
          g_q      <= in_data;
          byte_cnt <= 2'd2;
        end
        default: byte_cnt <= 2'd0;
      endcase
    end
  end

  assign pixel_complete = accept && (byte_cnt == LAST_BYTE_SLOT);
  assign pixel          = {r_q, g_q, in_data};

endmodule

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - streams host RGB bytes into a strand of pixel words in memory
// Optional FRAME_WRITER_CHECKSUM_EN adds an 8-bit running sum of accepted bytes.
module frame_writer
  import hydra_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH     = DEF_MEM_ADDR_WIDTH,
  parameter int STRAND_PARAM_WIDTH = DEF_STRAND_PARAM_WIDTH,
  parameter int MEM_DATA_WIDTH     = DEF_MEM_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [STRAND_PARAM_WIDTH-1:0] strand_offset,
  input  logic [STRAND_PARAM_WIDTH-1:0] strand_length,
  input  logic [BYTE_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
  output logic [MEM_DATA_WIDTH-1:0]     mem_wdata,
  output logic                          mem_we,
  input  logic                          mem_ack,
  output logic                          busy,
  output logic                          done
`ifdef FRAME_WRITER_CHECKSUM_EN
  ,
  output logic [BYTE_WIDTH-1:0]         checksum
`endif
);

  state_t                        state;
  logic [STRAND_PARAM_WIDTH-1:0] offset_q;
  logic [STRAND_PARAM_WIDTH-1:0] length_q;
  logic [STRAND_PARAM_WIDTH-1:0] index_q;
  logic [STRAND_PARAM_WIDTH-1:0] index_inc;
  logic [MEM_ADDR_WIDTH-1:0]     pixel_addr;
  logic [PIXEL_WIDTH-1:0]        pixel;
  logic                          pixel_complete;
  logic                          byte_accept;
  logic                          start_accept;

  assign byte_accept  = in_valid && in_ready;
  assign start_accept = start && (state == ST_IDLE);
  assign index_inc    = index_q + 1'b1;
  // Widen before adding so an offset near the top of its range carries into higher address bits.
  assign pixel_addr   = MEM_ADDR_WIDTH'(offset_q) + MEM_ADDR_WIDTH'(index_q);

  pixel_packer u_packer (
    .clk            (clk),
    .rst            (rst),
    .clear          (start_accept),
    .in_data        (in_data),
    .accept         (byte_accept),
    .pixel          (pixel),
    .pixel_complete (pixel_complete)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      offset_q  <= '0;
      length_q  <= '0;
      index_q   <= '0;
      in_ready  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            offset_q <= strand_offset;
            length_q <= strand_length;
            index_q  <= '0;
            busy     <= 1'b1;
            in_ready <= (strand_length != '0);
            state    <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          // An empty strand is resolved from the latched length, one cycle after start.
          if (length_q == '0) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (pixel_complete) begin
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= pixel_addr;
            mem_wdata <= MEM_DATA_WIDTH'(pixel);
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            mem_we  <= 1'b0;
            index_q <= index_inc;
            if (index_inc == length_q) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= ST_COLLECT;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          mem_we   <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FRAME_WRITER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || start_accept) begin
      checksum <= '0;
    end else if (byte_accept) begin
      checksum <= add_mod256(checksum, in_data);
    end
  end
`else
  // Default build carries no checksum state.
`endif

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - directed self-checking bench for frame_writer
module tb_frame_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] strand_offset;
  logic [15:0] strand_length;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_we;
  logic        mem_ack;
  logic        busy;
  logic        done;
`ifdef FRAME_WRITER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]  bytes_q[$];
  logic [23:0] waddr[$];
  logic [23:0] wdata[$];
  int done_cnt, accepted, ack_edge, done_edge;
  bit timeout, unstable, ready_during_we, latency_bad;

  frame_writer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .strand_offset (strand_offset),
    .strand_length (strand_length),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_ack       (mem_ack),
    .busy          (busy),
    .done          (done)
`ifdef FRAME_WRITER_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one strand: feeds bytes_q, acks writes after ack_delay wait cycles, records writes.
  // glitch_at >= 0 pulses a foreign start once that many bytes have been accepted.
  task automatic run_strand(input logic [15:0] off, input logic [15:0] len,
                            input int ack_delay, input int glitch_at);
    int bi, wait_cnt;
    bit acc, pix_end, glitched;
    logic [23:0] hold_addr, hold_data;
    waddr.delete(); wdata.delete();
    done_cnt = 0; accepted = 0; ack_edge = -1; done_edge = -2;
    timeout = 0; unstable = 0; ready_during_we = 0; latency_bad = 0;
    bi = 0; wait_cnt = 0; glitched = 0;
    hold_addr = '0; hold_data = '0;
    start = 1'b1; strand_offset = off; strand_length = len;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 300 && done_cnt == 0; c++) begin
      if (mem_we && in_ready) ready_during_we = 1;
      start = 1'b0;
      if (glitch_at >= 0 && !glitched && accepted == glitch_at) begin
        start = 1'b1; strand_offset = 16'h0500; strand_length = 16'h0001; glitched = 1;
      end
      in_valid = (bi < bytes_q.size());
      in_data  = in_valid ? bytes_q[bi] : 8'h00;
      acc      = in_valid && in_ready;
      pix_end  = acc && (accepted % 3 == 2);
      mem_ack  = 1'b0;
      if (mem_we) begin
        if (wait_cnt == 0) begin
          hold_addr = mem_addr; hold_data = mem_wdata;
        end else if (mem_addr !== hold_addr || mem_wdata !== hold_data) begin
          unstable = 1;
        end
        if (wait_cnt == ack_delay) begin
          mem_ack = 1'b1;
          waddr.push_back(mem_addr); wdata.push_back(mem_wdata);
          ack_edge = cyc + 1; wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      @(posedge clk); #1;
      if (acc) begin bi++; accepted++; end
      if (pix_end && !mem_we) latency_bad = 1;
      if (done) begin done_cnt++; done_edge = cyc; end
    end
    start = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
    if (done_cnt == 0) timeout = 1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 24'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 000000", mem_addr); end
    checks++; if (mem_wdata !== 24'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 000000", mem_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_strand(16'h0100, 16'd2, 0, -1);
    checks++; if (timeout) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
    checks++; if (waddr.size() != 2) begin errors++; $display("FAIL basic_writes: got %0d expected 2", waddr.size()); end
    checks++; if (waddr[0] !== 24'h000100) begin errors++; $display("FAIL basic_addr0: got %h expected 000100", waddr[0]); end
    checks++; if (wdata[0] !== 24'h112233) begin errors++; $display("FAIL basic_data0: got %h expected 112233", wdata[0]); end
    checks++; if (waddr[1] !== 24'h000101) begin errors++; $display("FAIL basic_addr1: got %h expected 000101", waddr[1]); end
    checks++; if (wdata[1] !== 24'h445566) begin errors++; $display("FAIL basic_data1: got %h expected 445566", wdata[1]); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (latency_bad) begin errors++; $display("FAIL basic_we_latency: got late mem_we expected mem_we one cycle after last byte"); end
    checks++; if (done_edge != ack_edge) begin errors++; $display("FAIL basic_done_latency: got edge %0d expected %0d", done_edge, ack_edge); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_zero_length();
    bit saw_we, saw_ready;
    saw_we = 0; saw_ready = 0;
    in_valid = 1'b1; in_data = 8'h77;
    start = 1'b1; strand_offset = 16'h0300; strand_length = 16'h0000;
    @(posedge clk); #1;
    start = 1'b0;
    saw_we |= mem_we; saw_ready |= in_ready;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_early: got %b expected 0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    saw_we |= mem_we; saw_ready |= in_ready;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
    @(posedge clk); #1;
    saw_we |= mem_we; saw_ready |= in_ready;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_idle: got busy %b expected 0", busy); end
    checks++; if (saw_we) begin errors++; $display("FAIL zero_no_we: got mem_we 1 expected 0"); end
    checks++; if (saw_ready) begin errors++; $display("FAIL zero_no_ready: got in_ready 1 expected 0"); end
    in_valid = 1'b0;
  endtask

  task automatic test_addr_carry();
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_strand(16'hFFFF, 16'd2, 0, -1);
    checks++; if (waddr[0] !== 24'h00FFFF) begin errors++; $display("FAIL carry_addr0: got %h expected 00FFFF", waddr[0]); end
    checks++; if (waddr[1] !== 24'h010000) begin errors++; $display("FAIL carry_addr1: got %h expected 010000", waddr[1]); end
  endtask

  task automatic test_ack_delay();
    bytes_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    run_strand(16'h0020, 16'd2, 5, -1);
    checks++; if (timeout) begin errors++; $display("FAIL delay_timeout: got no done expected done"); end
    checks++; if (unstable) begin errors++; $display("FAIL delay_stable: got changing write outputs expected stable"); end
    checks++; if (ready_during_we) begin errors++; $display("FAIL delay_ready: got in_ready 1 during write expected 0"); end
    checks++; if (accepted != 6) begin errors++; $display("FAIL delay_accepted: got %0d expected 6", accepted); end
    checks++; if (wdata[1] !== 24'hD4E5F6) begin errors++; $display("FAIL delay_data1: got %h expected D4E5F6", wdata[1]); end
    checks++; if (done_edge != ack_edge) begin errors++; $display("FAIL delay_done_latency: got edge %0d expected %0d", done_edge, ack_edge); end
  endtask

  task automatic test_reset_mid();
    int bi;
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    bi = 0;
    start = 1'b1; strand_offset = 16'h0040; strand_length = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 30 && bi < 4; c++) begin
      in_valid = 1'b1; in_data = bytes_q[bi];
      mem_ack = mem_we;
      if (in_ready) bi++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; mem_ack = 1'b0;
    checks++; if (bi != 4) begin errors++; $display("FAIL rstmid_feed: got %0d bytes expected 4", bi); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 0", in_ready); end
    checks++; if (mem_addr !== 24'h0) begin errors++; $display("FAIL rstmid_mem_addr: got %h expected 000000", mem_addr); end
    checks++; if (mem_wdata !== 24'h0) begin errors++; $display("FAIL rstmid_mem_wdata: got %h expected 000000", mem_wdata); end
`ifdef FRAME_WRITER_CHECKSUM_EN
    checks++; if (checksum !== 8'h00) begin errors++; $display("FAIL rstmid_checksum: got %h expected 00", checksum); end
`endif
    bytes_q = '{8'hAA, 8'hBB, 8'hCC};
    run_strand(16'h0040, 16'd1, 0, -1);
    checks++; if (waddr.size() != 1) begin errors++; $display("FAIL rstmid_writes: got %0d expected 1", waddr.size()); end
    checks++; if (wdata[0] !== 24'hAABBCC) begin errors++; $display("FAIL rstmid_data: got %h expected AABBCC", wdata[0]); end
    checks++; if (waddr[0] !== 24'h000040) begin errors++; $display("FAIL rstmid_addr: got %h expected 000040", waddr[0]); end
  endtask

  task automatic test_start_ignored();
    bytes_q = '{8'hFF, 8'h02, 8'h01};
    run_strand(16'h0200, 16'd1, 2, 1);
    checks++; if (waddr.size() != 1) begin errors++; $display("FAIL ignore_writes: got %0d expected 1", waddr.size()); end
    checks++; if (waddr[0] !== 24'h000200) begin errors++; $display("FAIL ignore_addr: got %h expected 000200", waddr[0]); end
    checks++; if (wdata[0] !== 24'hFF0201) begin errors++; $display("FAIL ignore_data: got %h expected FF0201", wdata[0]); end
`ifdef FRAME_WRITER_CHECKSUM_EN
    checks++; if (checksum !== 8'h02) begin errors++; $display("FAIL checksum_value: got %h expected 02", checksum); end
`endif
  endtask

  task automatic test_back_to_back();
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    run_strand(16'h2000, 16'd3, 1, -1);
    checks++; if (waddr.size() != 3) begin errors++; $display("FAIL b2b_writes: got %0d expected 3", waddr.size()); end
    checks++; if (waddr[2] !== 24'h002002) begin errors++; $display("FAIL b2b_addr2: got %h expected 002002", waddr[2]); end
    checks++; if (wdata[2] !== 24'h070809) begin errors++; $display("FAIL b2b_data2: got %h expected 070809", wdata[2]); end
    checks++; if (unstable) begin errors++; $display("FAIL b2b_stable: got changing write outputs expected stable"); end
    bytes_q = '{8'h0A, 8'h0B, 8'h0C};
    run_strand(16'h3000, 16'd1, 0, -1);
    checks++; if (wdata[0] !== 24'h0A0B0C) begin errors++; $display("FAIL b2b_second_data: got %h expected 0A0B0C", wdata[0]); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; strand_offset = '0; strand_length = '0;
    in_data = '0; in_valid = 1'b0; mem_ack = 1'b0;
    test_reset();
    test_basic();
    test_zero_length();
    test_addr_carry();
    test_ack_delay();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
